alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/alu_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated ALU.
package alu_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last_winner+1, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_winner,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last_winner) + k) % NREQ;
            if (req[IDW'(j)]) begin
                found  = 1'b1;
                winner = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shared add/multiply ALU with round-robin arbitration among NREQ requesters.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       op,
    input  logic [NREQ*WIDTH-1:0] opa_flat,
    input  logic [NREQ*WIDTH-1:0] opb_flat,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      result,
    output logic                  result_valid,
    output logic [IDW-1:0]        result_id,
    output logic                  ovf
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic [IDW-1:0]   rid_q, rid_d;

    logic             pick_found;
    logic [IDW-1:0]   pick_id;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req         (req),
        .last_winner (last_q),
        .found       (pick_found),
        .winner      (pick_id)
    );

    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        if (op_q == OP_MUL) begin
            alu_res = prod[WIDTH-1:0];
            alu_ovf = |prod[2*WIDTH-1:WIDTH];
        end else begin
            alu_res = sum[WIDTH-1:0];
            alu_ovf = sum[WIDTH];
        end
    end

    // last_q doubles as the in-flight owner: it is only read in EXEC, right after a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        rid_d   = rid_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (pick_found) begin
                    state_d = ST_EXEC;
                    last_d  = pick_id;
                    op_d    = op[pick_id];
                    a_d     = opa_flat[int'(pick_id)*WIDTH +: WIDTH];
                    b_d     = opb_flat[int'(pick_id)*WIDTH +: WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                res_d   = alu_res;
                ovf_d   = alu_ovf;
                rid_d   = last_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            rid_q   <= rid_d;
        end
    end

    assign grant        = (state_q == ST_EXEC) ? (NREQ'(1) << last_q) : '0;
    assign busy         = (state_q == ST_EXEC) || (state_q == ST_RESP);
    assign result_valid = (state_q == ST_RESP);
    assign result       = res_q;
    assign result_id    = rid_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: expected results queued at request time, popped on result_valid.
module tb_alu_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  resetn;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op;
    logic [NREQ*WIDTH-1:0] opa_flat;
    logic [NREQ*WIDTH-1:0] opb_flat;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      result;
    logic                  result_valid;
    logic [IDW-1:0]        result_id;
    logic                  ovf;

    typedef struct {
        int         id;
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    alu_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .op           (op),
        .opa_flat     (opa_flat),
        .opb_flat     (opb_flat),
        .grant        (grant),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_lane(input int id, input logic o, input logic [7:0] a, input logic [7:0] b);
        op[id]                  = o;
        opa_flat[id*WIDTH +: WIDTH] = a;
        opb_flat[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input int id, input logic [7:0] r, input logic v);
        exp_t e;
        e.id = id; e.res = r; e.ovf = v;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (grant == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(grant), 32'(1) << id);
        chk("busy_exec", 32'(busy), 1);
    endtask

    task automatic run_one(input int id, input logic o, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic v);
        set_lane(id, o, a, b);
        req[id] = 1'b1;
        push(id, r, v);
        wait_grant(id);
        req[id] = 1'b0;
        @(negedge clk);
        chk("rv_latency", 32'(result_valid), 1);
        chk("grant_resp", 32'(grant), 0);
        @(negedge clk);
        chk("rv_pulse", 32'(result_valid), 0);
    endtask

    always @(negedge clk) begin
        if (grant != '0) chk("grant_onehot", $countones(grant), 1);
        if (resetn && result_valid) begin
            if (sb.size() == 0) chk("unexpected_rv", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("result_id", 32'(result_id), 32'(e.id));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[5];
        int prev;
        resetn = 1'b0; req = '0; op = '0; opa_flat = '0; opb_flat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(result_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_id", 32'(result_id), 0);
        chk("rst_ovf", 32'(ovf), 0);
        resetn = 1'b1;

        run_one(2, 1'b0, 8'd100, 8'd50, 8'd150, 1'b0);
        chk("hold_result", 32'(result), 150);
        chk("hold_id", 32'(result_id), 2);

        run_one(0, 1'b1, 8'd20, 8'd20, 8'd144, 1'b1);
        run_one(0, 1'b1, 8'd15, 8'd17, 8'd255, 1'b0);
        run_one(3, 1'b0, 8'd200, 8'd100, 8'd44, 1'b1);
        run_one(1, 1'b1, 8'd255, 8'd255, 8'd1, 1'b1);
        run_one(2, 1'b0, 8'd255, 8'd0, 8'd255, 1'b0);

        // operands change during EXEC must not affect the in-flight op
        set_lane(1, 1'b0, 8'd7, 8'd8);
        req[1] = 1'b1;
        push(1, 8'd15, 1'b0);
        wait_grant(1);
        req = '0;
        set_lane(1, 1'b1, 8'd200, 8'd99);
        repeat (3) @(negedge clk);

        // reset during EXEC discards the operation
        set_lane(3, 1'b0, 8'd1, 8'd2);
        req[3] = 1'b1;
        wait_grant(3);
        resetn = 1'b0;
        req = '0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rv", 32'(result_valid), 0);
        chk("mid_grant", 32'(grant), 0);
        chk("mid_result", 32'(result), 0);
        chk("mid_id", 32'(result_id), 0);
        chk("mid_ovf", 32'(ovf), 0);
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_rv", 32'(result_valid), 0);
        end

        // fairness: all four held, expected order 0,1,2,3,0
        for (int k = 0; k < NREQ; k++) set_lane(k, 1'b0, 8'(10*k + 1), 8'(k + 3));
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) push(order[k], 8'(11*order[k] + 4), 1'b0);
        req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(order[k]);
            if (k > 0) chk("grant_gap", 32'(cyc - prev), 2);
            prev = cyc;
        end
        req = '0;
        repeat (3) @(negedge clk);

        // last winner is 0: simultaneous 0 and 1 -> 1 first
        set_lane(0, 1'b0, 8'd5, 8'd6);
        set_lane(1, 1'b1, 8'd3, 8'd4);
        push(1, 8'd12, 1'b0);
        push(0, 8'd11, 1'b0);
        req = 4'b0011;
        wait_grant(1);
        req[1] = 1'b0;
        wait_grant(0);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
